// File: rtl/vga_timing_unit.sv
// 640x480@60 Hz VGA timing generator with delayed sync/blanking output stage.
// Optional frame counter is built only when VGA_FRAME_COUNTER_EN is defined.
module vga_timing_unit #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       colour_in,
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       colour_out,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic h_wrap;
  logic v_wrap;
  logic hs_raw;
  logic vs_raw;
  logic de_raw;
  logic de_pre;

  logic [SYNC_DELAY-1:0] hs_pipe;
  logic [SYNC_DELAY-1:0] vs_pipe;
  logic [SYNC_DELAY-1:0] de_pipe;

  assign h_wrap = (counter_H == H_LAST);
  assign v_wrap = (counter_V == V_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      counter_H <= '0;
      counter_V <= '0;
    end else if (h_wrap) begin
      counter_H <= '0;
      if (v_wrap)
        counter_V <= '0;
      else
        counter_V <= counter_V + 10'd1;
    end else begin
      counter_H <= counter_H + 10'd1;
    end
  end

  assign hs_raw = !((counter_H >= HS_START) && (counter_H < HS_END));
  assign vs_raw = !((counter_V >= VS_START) && (counter_V < VS_END));
  assign de_raw = (counter_H < H_VIS) && (counter_V < V_VIS);

  assign frame_start = (counter_H == 10'd0) && (counter_V == 10'd0);

  // Stage 0 takes the raw decode; the last stage is the visible output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      de_pipe <= '0;
    end else begin
      for (int i = SYNC_DELAY - 1; i > 0; i--) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        de_pipe[i] <= de_pipe[i-1];
      end
      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      de_pipe[0] <= de_raw;
    end
  end

  assign hsync      = hs_pipe[SYNC_DELAY-1];
  assign vsync      = vs_pipe[SYNC_DELAY-1];
  assign display_on = de_pipe[SYNC_DELAY-1];

  // Blanking uses the stage before display_on so colour_out lines up with it.
  generate
    if (SYNC_DELAY == 1) begin : g_pre_raw
      assign de_pre = de_raw;
    end else begin : g_pre_pipe
      assign de_pre = de_pipe[SYNC_DELAY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset)
      colour_out <= 1'b0;
    else
      colour_out <= de_pre & colour_in;
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)
      frame_cnt_q <= '0;
    else if (h_wrap && v_wrap)
      frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_unit.sv
// Bench for vga_timing_unit: a full-size and a tiny-geometry instance share reset and
// random colour input; expected outputs come from cycle-count arithmetic.
module tb_vga_timing_unit;

  logic clk = 1'b0;
  logic reset;
  logic colour_in;

  logic [9:0] b_ch, b_cv, t_ch, t_cv;
  logic       b_hs, b_vs, b_de, b_co, b_fs;
  logic       t_hs, t_vs, t_de, t_co, t_fs;
  logic [7:0] b_fc, t_fc;

  int checks = 0;
  int fails  = 0;
  int n;
  logic pc;
  logic rst_now;

  always #20 clk = ~clk;

  vga_timing_unit u_big (
    .clk(clk), .reset(reset), .colour_in(colour_in),
    .counter_H(b_ch), .counter_V(b_cv), .hsync(b_hs), .vsync(b_vs),
    .display_on(b_de), .colour_out(b_co), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_unit #(
    .H_ACTIVE(4), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_DELAY(1)
  ) u_tiny (
    .clk(clk), .reset(reset), .colour_in(colour_in),
    .counter_H(t_ch), .counter_V(t_cv), .hsync(t_hs), .vsync(t_vs),
    .display_on(t_de), .colour_out(t_co), .frame_start(t_fs), .frame_count(t_fc)
  );

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    assert (act === exp)
    else begin
      fails++;
      $error("FAIL %s at n=%0d: observed %0d expected %0d", name, n, act, exp);
    end
  endtask

  // State n = cycles since the last reset edge; outputs follow from (n mod totals).
  task automatic check_unit(
    input string tag, input int cyc, input logic prev_c,
    input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb, input int d,
    input logic [9:0] ch, input logic [9:0] cv,
    input logic a_hs, input logic a_vs, input logic a_de, input logic a_co,
    input logic a_fs, input logic [7:0] a_fc);
    int ht, vt, h, v, m, hm, vm;
    logic e_hs, e_vs, e_de, e_co;
    logic [7:0] e_fc;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h  = cyc % ht;
    v  = (cyc / ht) % vt;
    if (cyc >= d) begin
      m    = cyc - d;
      hm   = m % ht;
      vm   = (m / ht) % vt;
      e_hs = !(hm >= ha + hf && hm < ha + hf + hs);
      e_vs = !(vm >= va + vf && vm < va + vf + vs);
      e_de = (hm < ha) && (vm < va);
    end else begin
      e_hs = 1'b1;
      e_vs = 1'b1;
      e_de = 1'b0;
    end
    e_co = e_de & prev_c;
`ifdef VGA_FRAME_COUNTER_EN
    e_fc = 8'((cyc / (ht * vt)) % 256);
`else
    e_fc = 8'h00;
`endif
    chk({tag, ".counter_H"},   ch, 10'(h));
    chk({tag, ".counter_V"},   cv, 10'(v));
    chk({tag, ".hsync"},       10'(a_hs), 10'(e_hs));
    chk({tag, ".vsync"},       10'(a_vs), 10'(e_vs));
    chk({tag, ".display_on"},  10'(a_de), 10'(e_de));
    chk({tag, ".colour_out"},  10'(a_co), 10'(e_co));
    chk({tag, ".frame_start"}, 10'(a_fs), 10'((h == 0) && (v == 0)));
    chk({tag, ".frame_count"}, 10'(a_fc), 10'(e_fc));
  endtask

  initial begin
    reset     = 1'b0;
    colour_in = 1'b0;
    pc        = 1'b0;
    n         = 0;
    repeat (3) @(posedge clk);
    // 257 tiny frames (70 cycles each) after the mid-run reset pulse at step 500.
    for (int step = 0; step < 18600; step++) begin
      @(negedge clk);
      check_unit("big", n, pc, 640, 16, 96, 48, 480, 10, 2, 33, 3,
                 b_ch, b_cv, b_hs, b_vs, b_de, b_co, b_fs, b_fc);
      check_unit("tiny", n, pc, 4, 2, 3, 1, 3, 1, 2, 1, 1,
                 t_ch, t_cv, t_hs, t_vs, t_de, t_co, t_fs, t_fc);
      rst_now   = (step == 500);
      reset     = !rst_now;
      colour_in = 1'($urandom_range(0, 1));
      pc        = colour_in;
      n         = rst_now ? 0 : n + 1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
